// File: rtl/mpt_pkg.sv
// Shared MPT walker types and the fetch-stage SPA/MODE format check.
// Latency: none (types plus a combinational helper function).
// Backpressure: none.
package mpt_pkg;

  typedef enum logic [1:0] {
    NO_ERROR           = 2'd0,
    NOT_VALID_ADDR     = 2'd1,
    MPT_ACCESS_FAULT   = 2'd2,
    MPT_RESERVED_FAULT = 2'd3
  } page_format_fault_e;

  // Encodings 4..15 are reserved and rejected by the format check.
  typedef enum logic [3:0] {
    BARE_MODE = 4'd0,
    SMMPT43   = 4'd1,
    SMMPT52   = 4'd2,
    SMMPT64   = 4'd3
  } mmpt_mode_e;

  typedef enum logic {
    MPT_WALKING_DO   = 1'b0,
    MPT_WALKING_SKIP = 1'b1
  } mpt_walking_e;

  typedef struct packed {
    mmpt_mode_e  mode;
    logic [7:0]  sdid;
    logic [19:0] ppn;
  } mmpt_reg_t;

  typedef struct packed {
    logic [20:0] ZERO;
    logic [42:0] spa;
  } spa43_t;

  typedef struct packed {
    logic [11:0] ZERO;
    logic [51:0] spa;
  } spa52_t;

  typedef union packed {
    spa43_t      spa43;
    spa52_t      spa52;
    logic [63:0] spa64;
  } spa_t_u;

  typedef struct packed {
    logic               valid;
    mmpt_reg_t          mmpt;
    spa_t_u             spa;
    logic [1:0]         access_type;
    logic [2:0]         access_error;
    page_format_fault_e format_error;
    mpt_walking_e       walking;
  } mptw_transaction_t;

  // Upper SPA bits beyond the mode's address width must be zero; bare/reserved modes cannot walk.
  function automatic page_format_fault_e mpt_check_format(input mmpt_reg_t mmpt, input spa_t_u spa);
    page_format_fault_e res;
    res = NO_ERROR;
    case (mmpt.mode)
      SMMPT43: if (spa.spa43.ZERO != '0) res = NOT_VALID_ADDR;
      SMMPT52: if (spa.spa52.ZERO != '0) res = NOT_VALID_ADDR;
      SMMPT64: res = NO_ERROR;
      default: res = NOT_VALID_ADDR;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mpt_fetch_fifo.sv
// Per-channel request FIFO with wrap-bit pointers and a synchronous clear.
// Latency: pushed entry visible at dout the cycle after the push.
// Backpressure: full asserted from registered pointers; pushes while full are ignored.
module mpt_fetch_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset and flush both return the FIFO to empty.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mpt_fetch_arbiter.sv
// Multi-channel MPT fetch: per-channel FIFOs, round-robin pick, SPA/MODE check, registered issue.
// Latency: push to m_valid_o in 2 cycles; one transaction per cycle while m_ready_i stays high.
// Backpressure: s_ready_o low on full FIFO or flush; output register holds while !m_ready_i.
// Optional MPT_FETCH_PERF_EN: adds perf_acc_o / perf_fault_o saturating counters.
module mpt_fetch_arbiter
  import mpt_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_WIDTH = $bits(mptw_transaction_t),
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH-1:0]            s_valid_i,
  output logic [NUM_CH-1:0]            s_ready_o,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [DATA_WIDTH-1:0]        m_data_o,
  output logic [CH_W-1:0]              m_ch_o,
  input  logic                         flush_i,
  output logic                         exc_valid_o,
  output page_format_fault_e           exc_cause_o,
  output logic [CH_W-1:0]              exc_ch_o
`ifdef MPT_FETCH_PERF_EN
  ,
  output logic [NUM_CH*32-1:0]         perf_acc_o,
  output logic [31:0]                  perf_fault_o
`endif
);

  logic [NUM_CH-1:0]     fifo_full;
  logic [NUM_CH-1:0]     fifo_empty;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     pop;
  logic [DATA_WIDTH-1:0] fifo_dout [NUM_CH];

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_nxt;
  logic [CH_W-1:0]   gnt_ch;
  logic [CH_W-1:0]   scan_ch;
  logic              gnt_vld;
  logic              load_en;
  logic              chk_fault;
  mptw_transaction_t sel_txn;
  mptw_transaction_t chk_txn;
  mptw_transaction_t m_q;

  // Full comes straight from registered pointers, so a full channel stays closed even on its pop cycle.
  assign s_ready_o = rst_ni ? (~fifo_full & {NUM_CH{~flush_i}}) : '0;
  assign push      = s_valid_i & s_ready_o;
  assign load_en   = !m_valid_o || m_ready_i;
  assign m_data_o  = m_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    mpt_fetch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .flush (flush_i),
      .push  (push[g]),
      .din   (s_data_i[g*DATA_WIDTH +: DATA_WIDTH]),
      .pop   (pop[g]),
      .dout  (fifo_dout[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  // Round-robin search: first non-empty channel at or after rr_ptr, wrapping cyclically.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    scan_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_ch = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!gnt_vld && !fifo_empty[scan_ch]) begin
        gnt_vld = 1'b1;
        gnt_ch  = scan_ch;
      end
    end
    rr_nxt = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
  end

  // Pop the granted channel only when the output register can take the entry.
  always_comb begin
    pop = '0;
    if (load_en && gnt_vld && !flush_i) pop[gnt_ch] = 1'b1;
  end

  // Format check on the selected head; invalid entries are passed as clean no-ops.
  always_comb begin
    sel_txn = fifo_dout[gnt_ch];
    chk_txn = sel_txn;
    if (sel_txn.valid) begin
      chk_txn.format_error = mpt_check_format(sel_txn.mmpt, sel_txn.spa);
    end else begin
      chk_txn.format_error = NO_ERROR;
      chk_txn.access_error = '0;
    end
    chk_fault       = (chk_txn.format_error != NO_ERROR);
    chk_txn.walking = chk_fault ? MPT_WALKING_SKIP : MPT_WALKING_DO;
  end

  // Output register, round-robin pointer and exception report; flush drops everything issued.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr      <= '0;
      m_valid_o   <= 1'b0;
      m_q         <= '0;
      m_ch_o      <= '0;
      exc_valid_o <= 1'b0;
      exc_cause_o <= NO_ERROR;
      exc_ch_o    <= '0;
    end else if (flush_i) begin
      rr_ptr      <= '0;
      m_valid_o   <= 1'b0;
      exc_valid_o <= 1'b0;
    end else begin
      exc_valid_o <= 1'b0;
      if (load_en) begin
        if (gnt_vld) begin
          m_q       <= chk_txn;
          m_ch_o    <= gnt_ch;
          m_valid_o <= 1'b1;
          rr_ptr    <= rr_nxt;
          if (chk_fault) begin
            exc_valid_o <= 1'b1;
            exc_cause_o <= chk_txn.format_error;
            exc_ch_o    <= gnt_ch;
          end
        end else begin
          m_valid_o <= 1'b0;
        end
      end
    end
  end

`ifdef MPT_FETCH_PERF_EN
  logic [31:0] acc_cnt [NUM_CH];
  logic [31:0] fault_cnt;

  // Saturating event counters; only reset clears them, flush leaves them intact.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) acc_cnt[c] <= '0;
      fault_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c] && (acc_cnt[c] != '1)) acc_cnt[c] <= acc_cnt[c] + 32'd1;
      end
      if (!flush_i && load_en && gnt_vld && chk_fault && (fault_cnt != '1)) begin
        fault_cnt <= fault_cnt + 32'd1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_perf
    assign perf_acc_o[c*32 +: 32] = acc_cnt[c];
  end
  assign perf_fault_o = fault_cnt;
`endif

endmodule

// File: tb/tb_mpt_fetch_arbiter.sv
// Self-checking bench for mpt_fetch_arbiter: vector table for the format check, scoreboard for issue order.
// Latency: n/a.
// Backpressure: driven explicitly by the test sequences.
module tb_mpt_fetch_arbiter;
  import mpt_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = $bits(mptw_transaction_t);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NCH-1:0]     s_valid;
  logic [NCH-1:0]     s_ready;
  logic [NCH*DW-1:0]  s_data;
  logic               m_valid;
  logic               m_ready;
  logic [DW-1:0]      m_data;
  logic [1:0]         m_ch;
  logic               flush;
  logic               exc_valid;
  page_format_fault_e exc_cause;
  logic [1:0]         exc_ch;
`ifdef MPT_FETCH_PERF_EN
  logic [NCH*32-1:0]  perf_acc;
  logic [31:0]        perf_fault;
`endif

  mpt_fetch_arbiter #(.NUM_CH(NCH), .FIFO_DEPTH(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .m_ch_o      (m_ch),
    .flush_i     (flush),
    .exc_valid_o (exc_valid),
    .exc_cause_o (exc_cause),
    .exc_ch_o    (exc_ch)
`ifdef MPT_FETCH_PERF_EN
    ,
    .perf_acc_o  (perf_acc),
    .perf_fault_o(perf_fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int                ch;
    mptw_transaction_t txn;
  } exp_t;

  typedef struct {
    mmpt_mode_e         mode;
    logic [63:0]        spa;
    logic               vld;
    page_format_fault_e err;
    mpt_walking_e       walk;
    logic [2:0]         aerr;
    logic               pulse;
  } vec_t;

  int                total = 0;
  int                bad   = 0;
  exp_t              sb[$];
  int                ch_log[$];
  bit                mon_en = 1'b0;
  mptw_transaction_t drv_txn [NCH];
  mptw_transaction_t drv_exp [NCH];
  vec_t              vt [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic mptw_transaction_t make_txn(input mmpt_mode_e mode, input logic [63:0] spa,
                                                 input logic vld, input logic [7:0] id);
    mptw_transaction_t t;
    t              = '0;
    t.valid        = vld;
    t.mmpt.mode    = mode;
    t.mmpt.sdid    = id;
    t.mmpt.ppn     = {12'h5a5, id};
    t.spa.spa64    = spa;
    t.access_type  = id[1:0];
    t.access_error = 3'b101;
    t.format_error = MPT_RESERVED_FAULT;
    t.walking      = MPT_WALKING_SKIP;
    return t;
  endfunction

  // Expected downstream form of a transaction that passes the format check.
  function automatic mptw_transaction_t exp_clean(input mptw_transaction_t t);
    mptw_transaction_t e;
    e              = t;
    e.format_error = NO_ERROR;
    e.walking      = MPT_WALKING_DO;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer drv_txn on the masked channels for one edge; accepted ones enter the scoreboard.
  task automatic cycle_push(input logic [NCH-1:0] mask, output logic [NCH-1:0] acc);
    logic [NCH-1:0] rdy;
    exp_t           e;
    s_valid = mask;
    for (int i = 0; i < NCH; i++) s_data[i*DW +: DW] = drv_txn[i];
    #1;
    rdy = s_ready;
    @(posedge clk);
    acc = mask & rdy;
    for (int i = 0; i < NCH; i++) begin
      if (acc[i]) begin
        e.ch  = i;
        e.txn = drv_exp[i];
        sb.push_back(e);
      end
    end
    #1;
    s_valid = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 200; c++) begin
      if (sb.size() == 0 && !m_valid) break;
      tick();
    end
    chk(name, sb.size(), 0);
  endtask

  // Scoreboard: each accepted output must match the oldest pending entry of its channel.
  always @(negedge clk) begin : mon
    int idx;
    if (mon_en && rst_n && m_valid && m_ready && !flush) begin
      idx = -1;
      foreach (sb[j]) if (idx < 0 && sb[j].ch == int'(m_ch)) idx = j;
      if (idx < 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got ch %0d data %0h, required no output", m_ch, m_data);
      end else begin
        chk($sformatf("sb_data_ch%0d", m_ch), m_data, sb[idx].txn);
        sb.delete(idx);
      end
      ch_log.push_back(int'(m_ch));
    end
  end

  initial begin
    logic [NCH-1:0] acc;
    int             rem [NCH];
    int             cnt [NCH];
    int             n_acc;
    mptw_transaction_t pre;

    vt[0] = '{SMMPT43, 64'h0000_0800_0000_0000, 1'b1, NOT_VALID_ADDR, MPT_WALKING_SKIP, 3'b101, 1'b1};
    vt[1] = '{mmpt_mode_e'(4'd9), 64'h0, 1'b1, NOT_VALID_ADDR, MPT_WALKING_SKIP, 3'b101, 1'b1};
    vt[2] = '{SMMPT43, 64'h0000_07ff_ffff_ffff, 1'b1, NO_ERROR, MPT_WALKING_DO, 3'b101, 1'b0};
    vt[3] = '{SMMPT52, 64'h0050_0000_0000_0000, 1'b1, NOT_VALID_ADDR, MPT_WALKING_SKIP, 3'b101, 1'b1};
    vt[4] = '{SMMPT52, 64'h000f_f800_0000_0000, 1'b1, NO_ERROR, MPT_WALKING_DO, 3'b101, 1'b0};
    vt[5] = '{BARE_MODE, 64'h0, 1'b1, NOT_VALID_ADDR, MPT_WALKING_SKIP, 3'b101, 1'b1};
    vt[6] = '{SMMPT64, 64'hffff_ffff_ffff_ffff, 1'b1, NO_ERROR, MPT_WALKING_DO, 3'b101, 1'b0};
    vt[7] = '{mmpt_mode_e'(4'd9), 64'hffff_0000_0000_0000, 1'b0, NO_ERROR, MPT_WALKING_DO, 3'b000, 1'b0};

    // T1: reset with every requester asserting valid
    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    s_valid = '1;
    s_data  = {NCH{make_txn(SMMPT64, 64'h1234, 1'b1, 8'h11)}};
    tick();
    tick();
    chk("t1_s_ready", s_ready, 0);
    chk("t1_m_valid", m_valid, 0);
    chk("t1_exc_cause", exc_cause, NO_ERROR);
    chk("t1_exc_valid", exc_valid, 0);
    chk("t1_m_ch", m_ch, 0);
    chk("t1_m_data", m_data, 0);
    rst_n   = 1'b1;
    s_valid = '0;
    tick();
    mon_en = 1'b1;

    // T2: three SMMPT64 requests per channel, ready held high
    ch_log.delete();
    for (int i = 0; i < NCH; i++) begin
      rem[i] = 3;
      cnt[i] = 0;
    end
    for (int c = 0; c < 100; c++) begin
      logic [NCH-1:0] mask;
      mask = '0;
      for (int i = 0; i < NCH; i++) begin
        mask[i]    = (rem[i] > 0);
        drv_txn[i] = make_txn(SMMPT64, 64'(i) << 40, 1'b1, 8'(i * 16 + cnt[i]));
        drv_exp[i] = exp_clean(drv_txn[i]);
      end
      if (mask == '0) break;
      cycle_push(mask, acc);
      for (int i = 0; i < NCH; i++) if (acc[i]) begin
        rem[i]--;
        cnt[i]++;
      end
      if (c == 0) chk("t2_no_valid_at_1", m_valid, 0);
      if (c == 1) begin
        chk("t2_valid_at_2", m_valid, 1);
        chk("t2_first_ch", m_ch, 0);
      end
    end
    wait_drain("t2_drain");
    chk("t2_count", ch_log.size(), 12);
    for (int k = 0; k < 12; k++) begin
      if (k < ch_log.size()) chk($sformatf("t2_order[%0d]", k), ch_log[k], k % 4);
    end

    // T3: format check vectors on channel 2
    for (int v = 0; v < 8; v++) begin
      drv_txn[2]              = make_txn(vt[v].mode, vt[v].spa, vt[v].vld, 8'(8'h80 + v));
      drv_exp[2]              = drv_txn[2];
      drv_exp[2].format_error = vt[v].err;
      drv_exp[2].walking      = vt[v].walk;
      drv_exp[2].access_error = vt[v].aerr;
      cycle_push(4'b0100, acc);
      chk($sformatf("t3_acc[%0d]", v), acc[2], 1);
      tick();
      chk($sformatf("t3_pulse[%0d]", v), exc_valid, vt[v].pulse);
      if (vt[v].pulse) begin
        chk($sformatf("t3_cause[%0d]", v), exc_cause, NOT_VALID_ADDR);
        chk($sformatf("t3_exc_ch[%0d]", v), exc_ch, 2);
      end
      tick();
      chk($sformatf("t3_pulse_end[%0d]", v), exc_valid, 0);
    end
    chk("t3_cause_held", exc_cause, NOT_VALID_ADDR);
    chk("t3_ch_held", exc_ch, 2);
    wait_drain("t3_drain");

    // T4: hold downstream ready low while ch1 keeps pushing
    m_ready    = 1'b0;
    pre        = make_txn(SMMPT64, 64'h40, 1'b1, 8'h40);
    drv_txn[1] = pre;
    drv_exp[1] = exp_clean(pre);
    cycle_push(4'b0010, acc);
    tick();
    chk("t4_loaded", m_valid, 1);
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      drv_txn[1] = make_txn(SMMPT64, 64'h41 + 64'(c), 1'b1, 8'(8'h41 + c));
      drv_exp[1] = exp_clean(drv_txn[1]);
      cycle_push(4'b0010, acc);
      if (acc[1]) n_acc++;
      chk($sformatf("t4_hold_data[%0d]", c), m_data, exp_clean(pre));
      chk($sformatf("t4_hold_valid[%0d]", c), m_valid, 1);
    end
    chk("t4_accepts", n_acc, 2);
    chk("t4_ready_low", s_ready[1], 0);
    m_ready = 1'b1;
    wait_drain("t4_drain");

    // T5: flush with work in the output register and FIFOs, plus a concurrent push
    m_ready    = 1'b0;
    drv_txn[0] = make_txn(SMMPT64, 64'h50, 1'b1, 8'h50);
    drv_exp[0] = exp_clean(drv_txn[0]);
    cycle_push(4'b0001, acc);
    tick();
    drv_txn[1] = make_txn(SMMPT64, 64'h51, 1'b1, 8'h51);
    drv_txn[3] = make_txn(SMMPT64, 64'h53, 1'b1, 8'h53);
    drv_exp[1] = exp_clean(drv_txn[1]);
    drv_exp[3] = exp_clean(drv_txn[3]);
    cycle_push(4'b1010, acc);
    chk("t5_pre_valid", m_valid, 1);
    flush   = 1'b1;
    s_valid = 4'b0100;
    s_data[2*DW +: DW] = make_txn(SMMPT64, 64'h52, 1'b1, 8'h52);
    #1;
    chk("t5_ready_in_flush", s_ready, 0);
    @(posedge clk);
    #1;
    flush   = 1'b0;
    s_valid = '0;
    chk("t5_valid_cleared", m_valid, 0);
    sb.delete();
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t5_stays_empty[%0d]", c), m_valid, 0);
    end
    ch_log.delete();
    drv_txn[0] = make_txn(SMMPT64, 64'h60, 1'b1, 8'h60);
    drv_txn[1] = make_txn(SMMPT64, 64'h61, 1'b1, 8'h61);
    drv_exp[0] = exp_clean(drv_txn[0]);
    drv_exp[1] = exp_clean(drv_txn[1]);
    cycle_push(4'b0011, acc);
    wait_drain("t5_drain");
    chk("t5_log_n", ch_log.size(), 2);
    if (ch_log.size() >= 2) begin
      chk("t5_rr_first", ch_log[0], 0);
      chk("t5_rr_second", ch_log[1], 1);
    end

    // Reset in the middle of a transfer leaves nothing behind
    m_ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      drv_txn[i] = make_txn(BARE_MODE, 64'h70, 1'b1, 8'(8'h70 + i));
      drv_exp[i] = drv_txn[i];
    end
    cycle_push(4'b1111, acc);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_valid", m_valid, 0);
    chk("rst_mid_ready", s_ready, 0);
    chk("rst_mid_cause", exc_cause, NO_ERROR);
    rst_n   = 1'b1;
    sb.delete();
    m_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_mid_no_residue", m_valid, 0);

`ifdef MPT_FETCH_PERF_EN
    // T6: counters for five ch3 pushes including two faults, then flush
    for (int i = 0; i < 5; i++) begin
      drv_txn[3] = make_txn((i == 1 || i == 3) ? BARE_MODE : SMMPT64, 64'h80, 1'b1, 8'(8'h90 + i));
      drv_exp[3] = exp_clean(drv_txn[3]);
      if (i == 1 || i == 3) begin
        drv_exp[3].format_error = NOT_VALID_ADDR;
        drv_exp[3].walking      = MPT_WALKING_SKIP;
      end
      cycle_push(4'b1000, acc);
    end
    wait_drain("t6_drain");
    chk("t6_acc_ch3", perf_acc[3*32 +: 32], 5);
    chk("t6_acc_ch0", perf_acc[0 +: 32], 0);
    chk("t6_fault", perf_fault, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("t6_acc_after_flush", perf_acc[3*32 +: 32], 5);
    chk("t6_fault_after_flush", perf_fault, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
